// File: rtl/sha3_absorb.sv
`default_nettype none
// ============================================================================
// Module      : sha3_absorb
// Description : SHA-3 absorb front end. XORs 64-bit message lanes into the
//               5x5 Keccak state, issues blocks to an external permutation
//               and holds the final state for the consumer. Optional
//               hardware pad10*1 is enabled by defining SHA3_ABSORB_PAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_absorb #(
    parameter int RATE_LANES = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic [4:0][63:0] osa,
    output logic [4:0][63:0] osb,
    output logic [4:0][63:0] osc,
    output logic [4:0][63:0] osd,
    output logic [4:0][63:0] ose,
    output logic             sample,
    input  logic             perm_done,
    input  logic [4:0][63:0] isa,
    input  logic [4:0][63:0] isb,
    input  logic [4:0][63:0] isc,
    input  logic [4:0][63:0] isd,
    input  logic [4:0][63:0] ise,
    output logic             state_valid,
    input  logic             ack
);

`ifdef SHA3_ABSORB_PAD_EN
    localparam bit c_pad_en = 1'b1;
`else
    localparam bit c_pad_en = 1'b0;
`endif

    localparam logic [4:0]  c_last_lane = 5'(RATE_LANES - 1);
    localparam logic [63:0] c_pad_first = 64'h0000_0000_0000_0006;
    localparam logic [63:0] c_pad_final = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        PAD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           r_fsm;
    state_t           w_fsm_next;
    logic [24:0][63:0] r_st;
    logic [4:0]        r_lane_idx;
    logic              r_pad_pending;
    logic              r_msg_end;

    logic              w_accept;
    logic              w_block_end;
    logic [24:0][63:0] w_is;
    logic [24:0][63:0] w_in_mask;
    logic [24:0][63:0] w_pad_mask;

    // Lane k = x + 5*y, so row y occupies lanes 5y..5y+4
    assign w_is = {ise, isd, isc, isb, isa};
    assign osa  = r_st[4:0];
    assign osb  = r_st[9:5];
    assign osc  = r_st[14:10];
    assign osd  = r_st[19:15];
    assign ose  = r_st[24:20];

    assign w_accept    = in_valid && in_ready;
    assign w_block_end = in_last || (r_lane_idx == c_last_lane);

    always_comb begin
        w_in_mask  = '0;
        w_pad_mask = '0;
        for (int k = 0; k < 25; k++) begin
            if ((k < RATE_LANES) && (5'(k) == r_lane_idx)) begin
                w_in_mask[k] = in_data;
            end
        end
        if (c_pad_en) begin
            if (r_fsm == PAD) begin
                w_pad_mask[0]            = w_pad_mask[0] ^ c_pad_first;
                w_pad_mask[RATE_LANES-1] = w_pad_mask[RATE_LANES-1] ^ c_pad_final;
            end else if (in_last && (r_lane_idx != c_last_lane)) begin
                for (int k = 0; k < 25; k++) begin
                    if (5'(k) == r_lane_idx + 5'd1) begin
                        w_pad_mask[k] = c_pad_first;
                    end
                end
                // XOR so the two pad bytes merge when they land on one lane
                w_pad_mask[RATE_LANES-1] = w_pad_mask[RATE_LANES-1] ^ c_pad_final;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= FILL;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next  = r_fsm;
        in_ready    = 1'b0;
        sample      = 1'b0;
        state_valid = 1'b0;
        unique case (r_fsm)
            FILL: begin
                in_ready = 1'b1;
                if (w_accept && w_block_end) begin
                    w_fsm_next = ISSUE;
                end
            end
            ISSUE: begin
                sample     = 1'b1;
                w_fsm_next = WAIT;
            end
            WAIT: begin
                if (perm_done) begin
                    if (r_pad_pending) begin
                        w_fsm_next = PAD;
                    end else if (r_msg_end) begin
                        w_fsm_next = DONE;
                    end else begin
                        w_fsm_next = FILL;
                    end
                end
            end
            PAD: begin
                w_fsm_next = ISSUE;
            end
            DONE: begin
                state_valid = 1'b1;
                if (ack) begin
                    w_fsm_next = FILL;
                end
            end
            default: begin
                w_fsm_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st          <= '0;
            r_lane_idx    <= '0;
            r_pad_pending <= 1'b0;
            r_msg_end     <= 1'b0;
        end else begin
            case (r_fsm)
                FILL: begin
                    if (w_accept) begin
                        r_st <= r_st ^ w_in_mask ^ w_pad_mask;
                        if (w_block_end) begin
                            r_lane_idx <= '0;
                        end else begin
                            r_lane_idx <= r_lane_idx + 5'd1;
                        end
                        if (in_last) begin
                            r_msg_end     <= 1'b1;
                            // A message ending on the last rate lane needs its own pad block
                            r_pad_pending <= c_pad_en && (r_lane_idx == c_last_lane);
                        end
                    end
                end
                WAIT: begin
                    if (perm_done) begin
                        r_st <= w_is;
                    end
                end
                PAD: begin
                    r_st          <= r_st ^ w_pad_mask;
                    r_pad_pending <= 1'b0;
                end
                DONE: begin
                    if (ack) begin
                        r_st          <= '0;
                        r_lane_idx    <= '0;
                        r_pad_pending <= 1'b0;
                        r_msg_end     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha3_absorb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha3_absorb
// Description : Scoreboard bench for sha3_absorb; expected issued blocks are
//               queued as words are driven and compared on each sample strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_absorb;

    localparam int R = 17;
    typedef logic [24:0][63:0] st_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_last;
    logic [4:0][63:0] osa, osb, osc, osd, ose;
    logic             sample;
    logic             perm_done;
    logic [4:0][63:0] isa, isb, isc, isd, ise;
    logic             state_valid;
    logic             ack;

    st_t os_all;
    assign os_all = {ose, osd, osc, osb, osa};

    int errors = 0;
    int checks = 0;

    st_t  exp_q[$];
    st_t  m_st;
    int   m_idx;
    bit   m_pad_pend;
    bit   m_end;

`ifdef SHA3_ABSORB_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    sha3_absorb #(.RATE_LANES(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .osa        (osa),
        .osb        (osb),
        .osc        (osc),
        .osd        (osd),
        .ose        (ose),
        .sample     (sample),
        .perm_done  (perm_done),
        .isa        (isa),
        .isb        (isb),
        .isc        (isc),
        .isd        (isd),
        .ise        (ise),
        .state_valid(state_valid),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input st_t got, input st_t exp);
        for (int k = 0; k < 25; k++) begin
            check_eq($sformatf("%s[%0d]", tag, k), got[k], exp[k]);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic m_reset();
        m_st       = '0;
        m_idx      = 0;
        m_pad_pend = 1'b0;
        m_end      = 1'b0;
        exp_q.delete();
    endtask

    // Every issued block must have been predicted, in order
    always @(negedge clk) begin
        if (!rst && sample) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_sample", 64'(sample), 64'd0);
            end else begin
                check_state("block", os_all, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [63:0] d, input bit last, output bit blk);
        int n;
        n   = 0;
        blk = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        m_st[m_idx] ^= d;
        if (PAD_ON && last) begin
            if (m_idx != R - 1) begin
                m_st[m_idx + 1] ^= 64'h06;
                m_st[R - 1]     ^= 64'h8000_0000_0000_0000;
            end else begin
                m_pad_pend = 1'b1;
            end
        end
        if (last || m_idx == R - 1) begin
            exp_q.push_back(m_st);
            m_idx = 0;
            m_end = last;
            blk   = 1'b1;
        end else begin
            m_idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (blk) begin
            check_eq("sample_latency", 64'(sample), 64'd1);
            check_eq("issue_ready", 64'(in_ready), 64'd0);
        end
    endtask

    task automatic do_perm(input int delay, input bit dead, output bit again);
        st_t v;
        for (int k = 0; k < 25; k++) v[k] = rnd64();
        if (dead) v[0] = 64'hDEAD;
        again = 1'b0;
        repeat (delay) begin
            check_eq("wait_ready", 64'(in_ready), 64'd0);
            check_eq("wait_valid", 64'(state_valid), 64'd0);
            @(negedge clk);
        end
        {ise, isd, isc, isb, isa} = v;
        perm_done = 1'b1;
        m_st = v;
        if (m_pad_pend) begin
            m_st[0]     ^= 64'h06;
            m_st[R - 1] ^= 64'h8000_0000_0000_0000;
            m_pad_pend   = 1'b0;
            exp_q.push_back(m_st);
            again = 1'b1;
        end
        @(negedge clk);
        perm_done = 1'b0;
    endtask

    task automatic run_msg(input int n, input logic [63:0] base, input bit rnd,
                           input bit dead, input int glitch_at);
        bit blk, again;
        for (int i = 0; i < n; i++) begin
            if (i == glitch_at) begin
                {ise, isd, isc, isb, isa} = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64(),
                                             rnd64(), rnd64(), rnd64(), rnd64(), rnd64(),
                                             rnd64(), rnd64(), rnd64(), rnd64(), rnd64(),
                                             rnd64(), rnd64(), rnd64(), rnd64(), rnd64(),
                                             rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
                perm_done = 1'b1;
                ack       = 1'b1;
                @(negedge clk);
                perm_done = 1'b0;
                ack       = 1'b0;
                check_state("fill_ignore", os_all, m_st);
            end
            send(rnd ? rnd64() : base + 64'(i), i == n - 1, blk);
            while (blk) begin
                do_perm(3 + (i % 4), dead && (i == n - 1), again);
                blk = again;
            end
        end
        check_eq("done_valid", 64'(state_valid), 64'd1);
        check_state("digest", os_all, m_st);
        repeat (3) @(negedge clk);
        check_eq("done_hold", 64'(state_valid), 64'd1);
        check_state("digest_hold", os_all, m_st);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_reset();
        check_eq("ack_ready", 64'(in_ready), 64'd1);
        check_eq("ack_valid", 64'(state_valid), 64'd0);
        check_state("ack_clear", os_all, '0);
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        check_state(tag, os_all, '0);
        check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
        repeat (4) begin
            check_eq({tag, "_nosample"}, 64'(sample), 64'd0);
            check_eq({tag, "_novalid"}, 64'(state_valid), 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        bit blk, again;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        perm_done = 1'b0;
        ack       = 1'b0;
        {ise, isd, isc, isb, isa} = '0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_ready", 64'(in_ready), 64'd1);
        check_eq("reset_sample", 64'(sample), 64'd0);
        check_eq("reset_valid", 64'(state_valid), 64'd0);
        check_state("reset_state", os_all, '0);

        // Words 1..17, final permutation returns 0xDEAD in lane 0
        run_msg(17, 64'd1, 1'b0, 1'b1, -1);
        // Single short word
        run_msg(1, 64'hAA, 1'b0, 1'b0, -1);
        // Spurious perm_done/ack in FILL, then 18 words across a block boundary
        run_msg(18, 64'd100, 1'b1, 1'b0, 2);

        // Reset mid-FILL
        for (int i = 0; i < 3; i++) send(rnd64(), 1'b0, blk);
        pulse_rst("rst_fill");
        // Reset in WAIT after a 3-word message
        for (int i = 0; i < 3; i++) send(rnd64(), i == 2, blk);
        repeat (2) @(negedge clk);
        pulse_rst("rst_wait");
        run_msg(5, 64'd0, 1'b1, 1'b0, -1);
        // Reset in DONE
        send(rnd64(), 1'b1, blk);
        do_perm(3, 1'b0, again);
        check_eq("pre_rst_done", 64'(state_valid), 64'd1);
        pulse_rst("rst_done");

        // Multi-block random messages, one ending on the last rate lane
        run_msg(34, 64'd0, 1'b1, 1'b0, -1);
        run_msg(40, 64'd0, 1'b1, 1'b0, -1);

        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
